// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
//
// N-bit add/subtract split into STAGES equal slices of W = N/STAGES bits. Each
// stage ripples one slice and registers the inter-slice carry, so the longest
// combinational carry path is W bits. Operand slices that have not been added
// yet travel in skew registers that shrink by W bits per stage. Finished low
// sum slices travel in de-skew registers that grow by W bits per stage, so the
// full N-bit result leaves the last stage in one beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; clears every valid and data register
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational on out_ready)
//   a, b       N-bit operands, unsigned or two's complement
//   cin        carry-in for add, borrow-in for subtract
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^N
//   co         raw carry out of bit N-1 (subtract: 1 means no borrow)
//   ovf        two's-complement overflow
//
// N must be divisible by STAGES, and 1 <= STAGES <= N.

module pipelined_carry_adder #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int unsigned W = N / STAGES;

  logic         advance;
  logic [N-1:0] b_eff;
  logic         c0;

  // Subtract is a + ~b + ~cin; the borrow-in becomes an inverted carry-in.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  // The whole pipe moves or holds as one; bubbles are not squeezed out.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0]       a_sl;
    logic [W-1:0]       b_sl;
    logic               c_in;
    logic               v_in;
    logic [W:0]         slice;
    logic [(k+1)*W-1:0] sum_d;
    logic [(k+1)*W-1:0] sum_q;
    logic               valid_q;
    logic               carry_q;

    if (k == 0) begin : g_in
      assign a_sl  = a[W-1:0];
      assign b_sl  = b_eff[W-1:0];
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = slice[W-1:0];
    end else begin : g_in
      // The next unprocessed slice always sits at the bottom of the skew register.
      assign a_sl  = g_stage[k-1].g_rem.a_rem_q[W-1:0];
      assign b_sl  = g_stage[k-1].g_rem.b_rem_q[W-1:0];
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign sum_d = {slice[W-1:0], g_stage[k-1].sum_q};
    end

    assign slice = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= v_in;
        carry_q <= slice[W];
        sum_q   <= sum_d;
      end
    end

    // Skew registers: operand bits above this stage's slice, still to be added.
    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned R = N - (k + 1) * W;
      logic [R-1:0] a_rem_d;
      logic [R-1:0] b_rem_d;
      logic [R-1:0] a_rem_q;
      logic [R-1:0] b_rem_q;

      if (k == 0) begin : g_src
        assign a_rem_d = a[N-1:W];
        assign b_rem_d = b_eff[N-1:W];
      end else begin : g_src
        assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[N-k*W-1:W];
        assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[N-k*W-1:W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (advance) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    // Overflow: carry into the MSB (a ^ b ^ s at the MSB) against carry out of it.
    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= a_sl[W-1] ^ b_sl[W-1] ^ slice[W-1] ^ slice[W];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign co        = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: three instances (STAGES = 1, 4, 16, N = 16)
// share one input stimulus; each keeps its own expected-result queue, fed only
// when that instance accepts a beat, and is checked against an arithmetic model.

module tb_pipelined_carry_adder;

  localparam int unsigned N = 16;
  localparam int          QSZ = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;

  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [2:0]   co_v;
  logic [2:0]   ovf_v;
  logic [N-1:0] sum_v [3];

  logic [17:0]  exp_mem [3][QSZ];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_carry_adder #(.N(N), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .sum(sum_v[0]), .co(co_v[0]), .ovf(ovf_v[0])
  );

  pipelined_carry_adder #(.N(N), .STAGES(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .sum(sum_v[1]), .co(co_v[1]), .ovf(ovf_v[1])
  );

  pipelined_carry_adder #(.N(N), .STAGES(16)) u_dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .sum(sum_v[2]), .co(co_v[2]), .ovf(ovf_v[2])
  );

  function automatic int stg(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  // Reference: {ovf, co, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(logic [15:0] x, logic [15:0] y, logic c, logic s);
    longint u;
    int     sx;
    int     sy;
    int     rs;
    logic   cy;
    logic   ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      u  = longint'(x) - longint'(y) - longint'(c);
      rs = sx - sy - int'(c);
      cy = (u >= 0);
    end else begin
      u  = longint'(x) + longint'(y) + longint'(c);
      rs = sx + sy + int'(c);
      cy = (u >= 65536);
    end
    ov = (rs > 32767) || (rs < -32768);
    return {ov, cy, u[15:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready_v !== 3'b000) begin
      failures++;
      $display("FAIL reset_in_ready actual=%b required=000", in_ready_v);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid_v[i], ovf_v[i], co_v[i], sum_v[i]} !== 19'h0) begin
        failures++;
        $display("FAIL reset_outputs stages=%0d actual v=%b ovf=%b co=%b sum=%h required all 0",
                 stg(i), out_valid_v[i], ovf_v[i], co_v[i], sum_v[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready_v !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset actual=%b required=111", in_ready_v);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [3];
    logic [15:0] tb_ [3];
    logic        tc [3];
    logic        ts [3];
    logic [17:0] te [3];
    int          cnt [3];
    ta[0] = 16'hFFFF; tb_[0] = 16'h0001; tc[0] = 1'b0; ts[0] = 1'b0; te[0] = {1'b0, 1'b1, 16'h0000};
    ta[1] = 16'h8000; tb_[1] = 16'h0001; tc[1] = 1'b0; ts[1] = 1'b1; te[1] = {1'b1, 1'b1, 16'h7FFF};
    ta[2] = 16'h0000; tb_[2] = 16'h0000; tc[2] = 1'b1; ts[2] = 1'b1; te[2] = {1'b0, 1'b0, 16'hFFFF};
    for (int v = 0; v < 3; v++) begin
      @(posedge clk);
      #1;
      a = ta[v]; b = tb_[v]; cin = tc[v]; sub = ts[v];
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (out_valid_v[i]) begin
            cnt[i]++;
            if (cnt[i] == 1) begin
              checks++;
              if (cyc != stg(i) - 1) begin
                failures++;
                $display("FAIL directed_latency vec=%0d stages=%0d actual=%0d required=%0d",
                         v, stg(i), cyc, stg(i) - 1);
              end
              checks++;
              if ({ovf_v[i], co_v[i], sum_v[i]} !== te[v]) begin
                failures++;
                $display("FAIL directed_result vec=%0d stages=%0d actual ovf/co/sum=%h required=%h",
                         v, stg(i), {ovf_v[i], co_v[i], sum_v[i]}, te[v]);
              end
            end
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] != 1) begin
          failures++;
          $display("FAIL directed_count vec=%0d stages=%0d actual=%0d required=1", v, stg(i), cnt[i]);
        end
      end
    end
  endtask

  task automatic test_stream(int beats, int vpct, int rpct);
    int head [3];
    int tail [3];
    int outs [3];
    int acc [3];
    int first_it [3];
    int last_it [3];
    int drain;
    int it;
    for (int i = 0; i < 3; i++) begin
      head[i] = 0; tail[i] = 0; outs[i] = 0; acc[i] = 0; first_it[i] = -1; last_it[i] = -1;
    end
    drain = 0;
    it = 0;
    while ((acc[1] < beats || drain < 40) && it < 20000) begin
      @(posedge clk);
      #1;
      if (acc[1] < beats) begin
        in_valid  = ($urandom_range(0, 99) < vpct);
        out_ready = ($urandom_range(0, 99) < rpct);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain++;
      end
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (out_valid_v[i]) begin
          checks++;
          if (head[i] == tail[i]) begin
            failures++;
            $display("FAIL stream_extra stages=%0d actual sum=%h required=no beat", stg(i), sum_v[i]);
          end else begin
            // Checked every cycle the beat is presented, so a stall must hold it.
            if ({ovf_v[i], co_v[i], sum_v[i]} !== exp_mem[i][head[i] % QSZ]) begin
              failures++;
              $display("FAIL stream_data stages=%0d beat=%0d actual ovf/co/sum=%h required=%h",
                       stg(i), head[i], {ovf_v[i], co_v[i], sum_v[i]}, exp_mem[i][head[i] % QSZ]);
            end
            if (out_ready) begin
              head[i]++;
              outs[i]++;
              if (first_it[i] < 0) first_it[i] = it;
              last_it[i] = it;
            end
          end
        end
        if (in_valid && in_ready_v[i]) begin
          exp_mem[i][tail[i] % QSZ] = model(a, b, cin, sub);
          tail[i]++;
          acc[i]++;
        end
      end
      it++;
    end
    checks++;
    if (it >= 20000) begin
      failures++;
      $display("FAIL stream_timeout actual=%0d required<20000", it);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (head[i] != tail[i] || outs[i] != acc[i]) begin
        failures++;
        $display("FAIL stream_lost stages=%0d actual out=%0d required=%0d", stg(i), outs[i], acc[i]);
      end
      if (vpct == 100 && rpct == 100) begin
        checks++;
        if (first_it[i] != stg(i)) begin
          failures++;
          $display("FAIL stream_first stages=%0d actual=%0d required=%0d", stg(i), first_it[i], stg(i));
        end
        checks++;
        if (outs[i] != beats || last_it[i] - first_it[i] + 1 != beats) begin
          failures++;
          $display("FAIL stream_rate stages=%0d actual out=%0d span=%0d required=%0d",
                   stg(i), outs[i], last_it[i] - first_it[i] + 1, beats);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    int          cnt [3];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_v !== 3'b000) begin
      failures++;
      $display("FAIL midreset_in_ready actual=%b required=000", in_ready_v);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_valid_v[i] !== 1'b0) begin
          failures++;
          $display("FAIL midreset_flushed stages=%0d cyc=%0d actual=%b required=0",
                   stg(i), cyc, out_valid_v[i]);
        end
      end
    end
    @(posedge clk);
    #1;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    e = model(a, b, cin, sub);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (out_valid_v[i]) begin
          cnt[i]++;
          checks++;
          if ({ovf_v[i], co_v[i], sum_v[i]} !== e || cyc != stg(i) - 1) begin
            failures++;
            $display("FAIL midreset_next stages=%0d actual %h@%0d required %h@%0d",
                     stg(i), {ovf_v[i], co_v[i], sum_v[i]}, cyc, e, stg(i) - 1);
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] != 1) begin
        failures++;
        $display("FAIL midreset_count stages=%0d actual=%0d required=1", stg(i), cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(100, 100, 100);
    test_stream(1000, 50, 50);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
